detector_sequencia: RTL and testbench

Parametrised serial pattern detector: compares a programmable WIDTH-bit word, with a per-bit don't-care mask, against a serial bit stream presented with a valid qualifier. Reports every match as a one-cycle pulse, supports overlapping and non-overlapping detection, and optionally counts matches. Sits in the serial receive path as the next generation of the fixed 8-bit sequence detector.

---
 rtl/detector_sequencia_pkg.sv | 14 +
 rtl/contador_saturado.sv | 26 ++
 rtl/detector_sequencia.sv | 137 +++++++++++++
 tb/tb_detector_sequencia.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/detector_sequencia_pkg.sv
// Shared types and limits for the serial pattern detector.
package detector_sequencia_pkg;

    localparam int unsigned STATE_W   = 2;
    localparam int unsigned WIDTH_MAX = 32;
    localparam int unsigned CNT_W_MAX = 16;

    typedef enum logic [STATE_W-1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StRun  = 2'd2
    } state_e;

endpackage

// File: rtl/contador_saturado.sv
// Saturating up-counter with synchronous reset and clear; used for the match count.
module contador_saturado #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_q
);

    logic [CNT_W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != {CNT_W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/detector_sequencia.sv
// Programmable masked serial pattern detector with overlap control.
// Optional match counter enabled by defining DETECTOR_SEQUENCIA_COUNT_EN.
module detector_sequencia
    import detector_sequencia_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_setar_palavra,
    input  logic [WIDTH-1:0] i_palavra,
    input  logic [WIDTH-1:0] i_mascara,
    input  logic             i_overlap,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_bit_valid,
    input  logic             i_bit_in,
    output logic             o_encontrado,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_match_count
);

    localparam int unsigned FILL_W = $clog2(WIDTH + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);

    if ((WIDTH < 2) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
        $error("detector_sequencia: WIDTH out of range");
    end
    if ((CNT_W < 1) || (CNT_W > CNT_W_MAX)) begin : g_bad_cnt_w
        $error("detector_sequencia: CNT_W out of range");
    end

    state_e            r_state;
    logic [WIDTH-1:0]  r_pat;
    logic [WIDTH-1:0]  r_msk;
    logic [WIDTH-1:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic              r_encontrado;

    state_e            w_state_nxt;
    logic [WIDTH-1:0]  w_pat_nxt;
    logic [WIDTH-1:0]  w_msk_nxt;
    logic [WIDTH-1:0]  w_hist_nxt;
    logic [FILL_W-1:0] w_fill_nxt;
    logic              w_enc_nxt;

    logic              w_accept;
    logic [WIDTH-1:0]  w_hist_shift;
    logic [FILL_W-1:0] w_fill_inc;
    logic              w_cmp_ok;
    logic              w_match;

    // Bits only count when no higher-priority control is active this cycle.
    assign w_accept     = (r_state != StIdle) && i_bit_valid &&
                          !i_setar_palavra && !i_stop && !i_start;
    assign w_hist_shift = {r_hist[WIDTH-2:0], i_bit_in};
    assign w_fill_inc   = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 1'b1;
    assign w_cmp_ok     = &((w_hist_shift ~^ r_pat) | ~r_msk);
    assign w_match      = w_accept && (w_fill_inc == FILL_FULL) && w_cmp_ok;

    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_msk_nxt   = r_msk;
        w_hist_nxt  = r_hist;
        w_fill_nxt  = r_fill;
        w_enc_nxt   = 1'b0;

        if (i_setar_palavra) begin
            w_pat_nxt   = i_palavra;
            w_msk_nxt   = i_mascara;
            w_hist_nxt  = '0;
            w_fill_nxt  = '0;
            w_state_nxt = StIdle;
        end else if (i_stop) begin
            w_state_nxt = StIdle;
        end else if (i_start) begin
            w_hist_nxt  = '0;
            w_fill_nxt  = '0;
            w_state_nxt = StFill;
        end else if (w_accept) begin
            w_enc_nxt = w_match;
            if (w_match && !i_overlap) begin
                w_hist_nxt  = '0;
                w_fill_nxt  = '0;
                w_state_nxt = StFill;
            end else begin
                w_hist_nxt  = w_hist_shift;
                w_fill_nxt  = w_fill_inc;
                w_state_nxt = (w_fill_inc == FILL_FULL) ? StRun : StFill;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_pat        <= '0;
            r_msk        <= '1;
            r_hist       <= '0;
            r_fill       <= '0;
            r_encontrado <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pat        <= w_pat_nxt;
            r_msk        <= w_msk_nxt;
            r_hist       <= w_hist_nxt;
            r_fill       <= w_fill_nxt;
            r_encontrado <= w_enc_nxt;
        end
    end

    assign o_encontrado = r_encontrado;
    assign o_busy       = (r_state != StIdle);

`ifdef DETECTOR_SEQUENCIA_COUNT_EN
    logic w_cnt_clr;

    // A start only clears the count when it restarts an armed detector.
    assign w_cnt_clr = i_setar_palavra ||
                       (!i_stop && i_start && (r_state != StIdle));

    contador_saturado #(
        .CNT_W (CNT_W)
    ) u_contador (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_cnt_clr),
        .i_inc (w_match),
        .o_q   (o_match_count)
    );
`else
    assign o_match_count = '0;
`endif

endmodule

// File: tb/tb_detector_sequencia.sv
// Bench for detector_sequencia: three parameterisations share one stimulus stream and are
// compared every cycle against a bit-count/history reference model.
module tb_detector_sequencia;

`ifdef DETECTOR_SEQUENCIA_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, setar, ovl, start, stop, bv, bi;
    logic [7:0] p8, m8;
    logic [2:0] p3, m3;
    logic [1:0] p2, m2;

    logic       enc8, busy8, enc3, busy3, enc2, busy2;
    logic [7:0] cnt8, cnt3;
    logic [1:0] cnt2;

    detector_sequencia #(.WIDTH(8), .CNT_W(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_setar_palavra(setar), .i_palavra(p8), .i_mascara(m8),
        .i_overlap(ovl), .i_start(start), .i_stop(stop), .i_bit_valid(bv), .i_bit_in(bi),
        .o_encontrado(enc8), .o_busy(busy8), .o_match_count(cnt8)
    );
    detector_sequencia #(.WIDTH(3), .CNT_W(8)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_setar_palavra(setar), .i_palavra(p3), .i_mascara(m3),
        .i_overlap(ovl), .i_start(start), .i_stop(stop), .i_bit_valid(bv), .i_bit_in(bi),
        .o_encontrado(enc3), .o_busy(busy3), .o_match_count(cnt3)
    );
    detector_sequencia #(.WIDTH(2), .CNT_W(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_setar_palavra(setar), .i_palavra(p2), .i_mascara(m2),
        .i_overlap(ovl), .i_start(start), .i_stop(stop), .i_bit_valid(bv), .i_bit_in(bi),
        .o_encontrado(enc2), .o_busy(busy2), .o_match_count(cnt2)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned n_p8 = 0, n_p3 = 0, n_p2 = 0;

    // Reference model: armed flag, accepted-bit count since last clear, shifted history.
    int unsigned mw[3]   = '{8, 3, 2};
    int unsigned mmax[3] = '{255, 255, 3};
    int unsigned m_pat[3], m_msk[3], m_hist[3], m_n[3], m_cnt[3];
    bit          m_arm[3], m_enc[3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int unsigned w, wm, pin, kin;
            w  = mw[k];
            wm = (32'd1 << w) - 32'd1;
            case (k)
                0:       begin pin = 32'(p8); kin = 32'(m8); end
                1:       begin pin = 32'(p3); kin = 32'(m3); end
                default: begin pin = 32'(p2); kin = 32'(m2); end
            endcase
            if (rst) begin
                m_pat[k] = 0; m_msk[k] = wm; m_hist[k] = 0; m_n[k] = 0;
                m_cnt[k] = 0; m_arm[k] = 0; m_enc[k] = 0;
            end else if (setar) begin
                m_pat[k] = pin; m_msk[k] = kin; m_hist[k] = 0; m_n[k] = 0;
                m_cnt[k] = 0; m_arm[k] = 0; m_enc[k] = 0;
            end else if (stop) begin
                m_arm[k] = 0; m_enc[k] = 0;
            end else if (start) begin
                if (m_arm[k]) m_cnt[k] = 0;
                m_arm[k] = 1; m_n[k] = 0; m_hist[k] = 0; m_enc[k] = 0;
            end else if (m_arm[k] && bv) begin
                m_hist[k] = ((m_hist[k] << 1) | 32'(bi)) & wm;
                m_n[k]++;
                if (m_n[k] >= w && ((m_hist[k] ^ m_pat[k]) & m_msk[k]) == 0) begin
                    m_enc[k] = 1;
                    if (m_cnt[k] < mmax[k]) m_cnt[k]++;
                    if (!ovl) begin
                        m_n[k] = 0; m_hist[k] = 0;
                    end
                end else begin
                    m_enc[k] = 0;
                end
            end else begin
                m_enc[k] = 0;
            end
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int k);
        return CNT_EN ? m_cnt[k] : 32'd0;
    endfunction

    task automatic check_all();
        chk("enc8", 32'(enc8), 32'(m_enc[0]));
        chk("busy8", 32'(busy8), 32'(m_arm[0]));
        chk("cnt8", 32'(cnt8), exp_cnt(0));
        chk("enc3", 32'(enc3), 32'(m_enc[1]));
        chk("busy3", 32'(busy3), 32'(m_arm[1]));
        chk("cnt3", 32'(cnt3), exp_cnt(1));
        chk("enc2", 32'(enc2), 32'(m_enc[2]));
        chk("busy2", 32'(busy2), 32'(m_arm[2]));
        chk("cnt2", 32'(cnt2), exp_cnt(2));
        if (enc8 === 1'b1) n_p8++;
        if (enc3 === 1'b1) n_p3++;
        if (enc2 === 1'b1) n_p2++;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic pulse_setar();
        setar = 1'b1; step(); setar = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic feed_bit(input logic b);
        bv = 1'b1; bi = b; step(); bv = 1'b0; bi = 1'b0;
    endtask

    task automatic feed_word(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) feed_bit(val[i]);
    endtask

    task automatic clear_pulses();
        n_p8 = 0; n_p3 = 0; n_p2 = 0;
    endtask

    initial begin
        rst = 1'b1; setar = 1'b0; ovl = 1'b0; start = 1'b0; stop = 1'b0;
        bv = 1'b0; bi = 1'b0;
        p8 = 8'h00; m8 = 8'hFF; p3 = 3'b000; m3 = 3'b111; p2 = 2'b00; m2 = 2'b11;
        step();
        step();
        chk("rst_enc8", 32'(enc8), 32'd0);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_cnt8", 32'(cnt8), 32'd0);
        rst = 1'b0;
        step();

        // Exact 8-bit word.
        p8 = 8'b1011_0011; m8 = 8'hFF;
        pulse_setar(); pulse_start(); clear_pulses();
        feed_word(32'hB3, 8);
        chk("s1_enc", 32'(enc8), 32'd1);
        step();
        chk("s1_enc_one_cycle", 32'(enc8), 32'd0);
        chk("s1_pulses", n_p8, 32'd1);
        chk("s1_cnt", 32'(cnt8), CNT_EN ? 32'd1 : 32'd0);

        // Overlap on/off with 3-bit pattern.
        p3 = 3'b101; m3 = 3'b111; ovl = 1'b1;
        pulse_setar(); pulse_start(); clear_pulses();
        feed_word(32'b10101, 5); step();
        chk("s2_ovl_pulses", n_p3, 32'd2);
        chk("s2_ovl_cnt", 32'(cnt3), CNT_EN ? 32'd2 : 32'd0);
        ovl = 1'b0;
        pulse_setar(); pulse_start(); clear_pulses();
        feed_word(32'b10101, 5); step();
        chk("s2_novl_pulses", n_p3, 32'd1);
        chk("s2_novl_cnt", 32'(cnt3), CNT_EN ? 32'd1 : 32'd0);

        // Masked compare: upper nibble only.
        p8 = 8'hA0; m8 = 8'hF0;
        pulse_setar(); pulse_start(); clear_pulses();
        feed_word(32'hA5, 8); step();
        chk("s3_a5_pulses", n_p8, 32'd1);
        clear_pulses();
        feed_word(32'hB5, 8); step();
        chk("s3_b5_pulses", n_p8, 32'd0);

        // Valid gap of 3 cycles between bits 4 and 5.
        p8 = 8'hB3; m8 = 8'hFF;
        pulse_setar(); pulse_start(); clear_pulses();
        feed_word(32'hB, 4);
        step(); step(); step();
        chk("s4_gap_pulses", n_p8, 32'd0);
        feed_word(32'h3, 4); step();
        chk("s4_pulses", n_p8, 32'd1);

        // Reload mid-stream drops the partial word and disarms.
        pulse_setar(); pulse_start(); clear_pulses();
        feed_word(32'b10110, 5);
        pulse_setar();
        chk("s5_busy", 32'(busy8), 32'd0);
        feed_word(32'b011, 3); step();
        chk("s5_pulses", n_p8, 32'd0);

        // Width 2, saturating 2-bit counter, then stop with a bit in the same cycle.
        p2 = 2'b11; m2 = 2'b11; ovl = 1'b1;
        pulse_setar(); pulse_start(); clear_pulses();
        for (int i = 0; i < 7; i++) feed_bit(1'b1);
        step();
        chk("s6_pulses", n_p2, 32'd6);
        chk("s6_cnt_sat", 32'(cnt2), CNT_EN ? 32'd3 : 32'd0);
        stop = 1'b1; bv = 1'b1; bi = 1'b1; step();
        stop = 1'b0; bv = 1'b0; bi = 1'b0;
        chk("s6_stop_busy", 32'(busy2), 32'd0);
        chk("s6_stop_enc", 32'(enc2), 32'd0);
        step();

        // Randomised traffic.
        for (int c = 0; c < 4000; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            setar = ($urandom_range(0, 63) == 0);
            start = ($urandom_range(0, 31) == 0);
            stop  = ($urandom_range(0, 79) == 0);
            bv    = ($urandom_range(0, 3) != 0);
            bi    = 1'($urandom);
            if ($urandom_range(0, 15) == 0) ovl = 1'($urandom);
            if (setar) begin
                p8 = 8'($urandom); m8 = 8'($urandom & $urandom);
                p3 = 3'($urandom); m3 = 3'($urandom);
                p2 = 2'($urandom); m2 = 2'($urandom);
            end
            step();
        end
        rst = 1'b0; setar = 1'b0; start = 1'b0; stop = 1'b0; bv = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
